// File: rtl/buzzer_pkg.sv
// Shared note codes and arbiter state encoding for the buzzer arbiter.
// Preemption is enabled by defining BUZZER_ARB_PREEMPT_EN.
package buzzer_pkg;

  localparam int NOTE_W = 4;

  localparam logic [NOTE_W-1:0] C_m  = 4'd0;
  localparam logic [NOTE_W-1:0] D_m  = 4'd1;
  localparam logic [NOTE_W-1:0] E_m  = 4'd2;
  localparam logic [NOTE_W-1:0] F_m  = 4'd3;
  localparam logic [NOTE_W-1:0] G_m  = 4'd4;
  localparam logic [NOTE_W-1:0] A_m  = 4'd5;
  localparam logic [NOTE_W-1:0] B_m  = 4'd6;
  localparam logic [NOTE_W-1:0] C2_m = 4'd7;
  localparam logic [NOTE_W-1:0] S_m  = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Codes above the last real note are played as silence.
  function automatic logic [NOTE_W-1:0] note_sat(
    input logic [NOTE_W-1:0] n
  );
    return (n > S_m) ? S_m : n;
  endfunction

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-set priority picker: returns a one-hot copy
// of the lowest set bit of the input vector (zero if none).
module prio_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_onehot
);

  logic [N-1:0] w_neg;

  assign w_neg    = -i_vec;
  assign o_onehot = i_vec & w_neg;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter with silent gap between owners.
// Define BUZZER_ARB_PREEMPT_EN to allow preemption after MIN_HOLD.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int MIN_HOLD   = 1000,
  parameter int GAP_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [4*N_REQ-1:0]  note_in,
  output logic [N_REQ-1:0]    grant,
  output logic [NOTE_W-1:0]   NS,
  output logic                enable,
  output logic                busy
);

  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [NOTE_W-1:0] r_ns;
  logic              r_en;
  logic              r_busy;
  logic [GW-1:0]     r_gap_cnt;

  logic [N_REQ-1:0]  w_pick;
  logic              w_own_req;
  logic [NOTE_W-1:0] w_own_note;
  logic              w_preempt;
  logic              w_release;

  prio_onehot #(.N(N_REQ)) u_prio (
    .i_vec    (req),
    .o_onehot (w_pick)
  );

  assign w_own_req = |(req & r_grant);

  always_comb begin
    w_own_note = S_m;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_own_note = note_in[4*i +: 4];
    end
  end

`ifdef BUZZER_ARB_PREEMPT_EN
  localparam int HW =
    (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  logic [HW-1:0] r_hold;

  // One-hot compare: a smaller pick is a higher-priority requester.
  assign w_preempt = (r_hold == HOLD_MAX) &&
                     (w_pick != '0) &&
                     (w_pick < r_grant);

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_GRANT) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  assign w_release = !w_own_req || w_preempt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ns      <= S_m;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_GRANT;
            r_grant <= w_pick;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_ns    <= S_m;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_grant   <= '0;
            r_en      <= 1'b0;
            r_ns      <= S_m;
            r_gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
            end
          end else begin
            r_ns <= note_sat(w_own_note);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_ns    <= S_m;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant  = r_grant;
  assign NS     = r_ns;
  assign enable = r_en;
  assign busy   = r_busy;

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; index 0 has the highest priority.
REQ-002 Parameter MIN_HOLD, default 1000: clk cycles an owner is protected from preemption.
REQ-003 Parameter GAP_CYCLES, default 50000: silent clk cycles inserted between owners.
REQ-004 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port req  input  N_REQ  per-requester request level.
REQ-007 Port note_in  input  4*N_REQ  requester i's note code on bits [4i+3:4i].
REQ-008 Port grant  output  N_REQ  one-hot owner indication; all-zero when no owner.
REQ-009 Port NS  output  4  note code to the tone generator.
REQ-010 Port enable  output  1  tone generator enable.
REQ-011 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-013 In IDLE, any req bit high SHALL register the lowest-index requester as owner and enter GRANT on the next edge: grant one-hot, enable=1; req-to-grant latency is 1 cycle.
REQ-014 In GRANT, NS SHALL follow the owner's note_in with 1-cycle latency; codes 9-15 SHALL be output as 8 (silence).
REQ-015 In GRANT, the owner dropping req SHALL enter GAP on the next edge, regardless of hold count.
REQ-016 hold_cnt SHALL clear on GRANT entry, increment each GRANT cycle and saturate at MIN_HOLD.
REQ-017 In GAP, grant SHALL be 0, enable SHALL be 0 and NS SHALL be 8; GAP SHALL last exactly GAP_CYCLES cycles, then enter IDLE.
REQ-018 When GAP_CYCLES=0, release SHALL go directly from GRANT to IDLE.
REQ-019 Requests arriving or dropping during GAP SHALL be ignored; arbitration occurs only in IDLE.
REQ-020 An owner drop and a preempting request in the same cycle SHALL take the single release path (REQ-015).
REQ-021 Counters SHALL be wide enough for their parameter (clog2(max+1)) and SHALL never wrap.

Reset
REQ-022 While rst is high at a clk edge, state SHALL be IDLE, grant=0, enable=0, NS=8, busy=0 and both counters 0, including mid-GRANT or mid-GAP.
REQ-023 On the first edge after rst deasserts, normal IDLE arbitration SHALL apply.

Configuration
REQ-024 Macro BUZZER_ARB_PREEMPT_EN defined: in GRANT with hold_cnt==MIN_HOLD, any req bit of lower index than the owner SHALL force GAP on the next edge.
REQ-025 Macro BUZZER_ARB_PREEMPT_EN undefined: the owner SHALL keep the buzzer until it drops req; hold_cnt MAY be omitted.

Structure
REQ-026 Shared package buzzer_pkg SHALL hold the note codes C_m=0 ... C2_m=7, S_m=8, NOTE_W=4 and the arbiter state encoding.
REQ-027 Sub-module prio_onehot SHALL take an N_REQ request vector and return a one-hot lowest-index-set vector; it is used for both grant and preemption compare.

Verification (bench uses N_REQ=3, MIN_HOLD=4, GAP_CYCLES=3)
REQ-028 rst high 2 cycles mid-GRANT -> the next cycle shows grant=000, enable=0, NS=8, busy=0.
REQ-029 IDLE, req=110 with note_in[1]=2 -> one edge later grant=010, enable=1; NS=2 on the following cycle.
REQ-030 Owner 1 drops req -> exactly 3 cycles with grant=000, enable=0, NS=8, busy=1, then IDLE; pending req 2 is granted on the next edge.
REQ-031 PREEMPT_EN, owner 2, req0 rises at hold_cnt=2 -> no change until hold_cnt=4, then GAP, then grant=001.
REQ-032 Without PREEMPT_EN, owner 2 with req0 high for 20 cycles -> grant stays 100 until req2 drops.
REQ-033 Owner note_in=12 -> NS=8 while enable=1.
